jtag_host: RTL

JTAG_HOST -- requirements
Module: jtag_host

---
 rtl/jtag_pkg.sv | 74 +++++++
 rtl/jtag_tap_tracker.sv | 28 ++
 rtl/jtag_host.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/jtag_pkg.sv
// ============================================================================
// jtag_pkg : shared types for the JTAG host (TAP encoding, ops, host FSM)
// Revision : 1.0
// ============================================================================
`default_nettype none

package jtag_pkg;

  typedef enum logic [3:0] {
    TAP_EX2_DR   = 4'h0,
    TAP_EX1_DR   = 4'h1,
    TAP_SHIFT_DR = 4'h2,
    TAP_PAUSE_DR = 4'h3,
    TAP_SEL_IR   = 4'h4,
    TAP_UPD_DR   = 4'h5,
    TAP_CAP_DR   = 4'h6,
    TAP_SEL_DR   = 4'h7,
    TAP_EX2_IR   = 4'h8,
    TAP_EX1_IR   = 4'h9,
    TAP_SHIFT_IR = 4'hA,
    TAP_PAUSE_IR = 4'hB,
    TAP_RTI      = 4'hC,
    TAP_UPD_IR   = 4'hD,
    TAP_CAP_IR   = 4'hE,
    TAP_TLR      = 4'hF
  } tap_state_e;

  typedef enum logic [1:0] {
    OP_TLR  = 2'b00,
    OP_IR   = 2'b01,
    OP_DR   = 2'b10,
    OP_IDLE = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_READY   = 3'd1,
    ST_PRE     = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_POST    = 3'd4,
    ST_IDLECLK = 3'd5,
    ST_DONE    = 3'd6
  } host_state_e;

  localparam int unsigned TLR_TMS_ONES = 5;

  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    tap_state_e n;
    n = TAP_TLR;
    case (s)
      TAP_TLR:      n = tms ? TAP_TLR    : TAP_RTI;
      TAP_RTI:      n = tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_DR:   n = tms ? TAP_SEL_IR : TAP_CAP_DR;
      TAP_CAP_DR:   n = tms ? TAP_EX1_DR : TAP_SHIFT_DR;
      TAP_SHIFT_DR: n = tms ? TAP_EX1_DR : TAP_SHIFT_DR;
      TAP_EX1_DR:   n = tms ? TAP_UPD_DR : TAP_PAUSE_DR;
      TAP_PAUSE_DR: n = tms ? TAP_EX2_DR : TAP_PAUSE_DR;
      TAP_EX2_DR:   n = tms ? TAP_UPD_DR : TAP_SHIFT_DR;
      TAP_UPD_DR:   n = tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_IR:   n = tms ? TAP_TLR    : TAP_CAP_IR;
      TAP_CAP_IR:   n = tms ? TAP_EX1_IR : TAP_SHIFT_IR;
      TAP_SHIFT_IR: n = tms ? TAP_EX1_IR : TAP_SHIFT_IR;
      TAP_EX1_IR:   n = tms ? TAP_UPD_IR : TAP_PAUSE_IR;
      TAP_PAUSE_IR: n = tms ? TAP_EX2_IR : TAP_PAUSE_IR;
      TAP_EX2_IR:   n = tms ? TAP_UPD_IR : TAP_SHIFT_IR;
      TAP_UPD_IR:   n = tms ? TAP_SEL_DR : TAP_RTI;
      default:      n = TAP_TLR;
    endcase
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/jtag_tap_tracker.sv
// ============================================================================
// jtag_tap_tracker : mirror of the target TAP state, driven by our own TMS
// Revision : 1.0
// ============================================================================
`default_nettype none

module jtag_tap_tracker
  import jtag_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tms_i,
  output tap_state_e tap_state_o
);

  tap_state_e tap_q;

  // TMS is forced high during reset, so the target is in TLR when we leave it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tap_q <= TAP_TLR;
    else        tap_q <= tap_next(tap_q, tms_i);
  end

  assign tap_state_o = tap_q;

endmodule

`default_nettype wire

// File: rtl/jtag_host.sv
// ============================================================================
// jtag_host : command-driven JTAG master (TLR, IR/DR scans, idle clocking)
// Revision : 1.0
// ============================================================================
`default_nettype none

module jtag_host
  import jtag_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LENW  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LENW-1:0]  cmd_len,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy,
  output logic             tms,
  output logic             tdi,
  input  logic             tdo
);

  localparam logic [LENW-1:0] WIDTH_L   = LENW'(WIDTH);
  localparam logic [LENW-1:0] INIT_LAST = LENW'(TLR_TMS_ONES);
  localparam logic [LENW-1:0] ONE_L     = LENW'(1);

  host_state_e      state_q, state_d;
  cmd_op_e          op_q, op_d;
  logic [LENW-1:0]  cnt_q, cnt_d, n_q, n_d, pre_last;
  logic [WIDTH-1:0] sh_q, sh_d, cap_q, cap_d, rsp_q, rsp_d;
  logic             rsp_valid_q, rsp_valid_d, tlr_rsp_q, tlr_rsp_d;
  logic             tms_q, tms_d, tdi_q, tdi_d;
  tap_state_e       tap_state;
  logic             tap_shifting;

  jtag_tap_tracker u_tap (
    .clk         (clk),
    .rst_n       (rst_n),
    .tms_i       (tms_q),
    .tap_state_o (tap_state)
  );

  assign tap_shifting = (tap_state == TAP_SHIFT_DR) || (tap_state == TAP_SHIFT_IR);
  assign pre_last     = (op_q == OP_IR) ? LENW'(3) : LENW'(2);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    sh_d        = sh_q;
    cap_d       = cap_q;
    rsp_d       = rsp_q;
    rsp_valid_d = 1'b0;
    tlr_rsp_d   = tlr_rsp_q;
    tms_d       = 1'b0;
    tdi_d       = 1'b0;

    case (state_q)
      ST_INIT: begin
        if (cnt_q == INIT_LAST) begin
          state_d     = ST_READY;
          cnt_d       = '0;
          rsp_valid_d = tlr_rsp_q;
          tlr_rsp_d   = 1'b0;
          if (tlr_rsp_q) rsp_d = '0;
        end else begin
          cnt_d = cnt_q + ONE_L;
        end
      end
      ST_READY: begin
        if (cmd_valid) begin
          op_d  = cmd_op_e'(cmd_op);
          sh_d  = cmd_data;
          cap_d = '0;
          cnt_d = '0;
          if (cmd_len == '0)          n_d = ONE_L;
          else if (cmd_len > WIDTH_L) n_d = WIDTH_L;
          else                        n_d = cmd_len;
          case (op_d)
            OP_TLR: begin
              state_d   = ST_INIT;
              tlr_rsp_d = 1'b1;
            end
            OP_IDLE: state_d = ST_IDLECLK;
            default: state_d = ST_PRE;
          endcase
        end
      end
      ST_PRE: begin
        if (cnt_q == pre_last) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE_L;
        end
      end
      ST_SHIFT: begin
        // capture fills from the top; right-justified once the length is known
        if (tap_shifting) cap_d = {tdo, cap_q[WIDTH-1:1]};
        sh_d = sh_q >> 1;
        if (cnt_q == n_q - ONE_L) state_d = ST_POST;
        else                      cnt_d   = cnt_q + ONE_L;
      end
      ST_POST: state_d = ST_DONE;
      ST_DONE: begin
        state_d     = ST_READY;
        rsp_valid_d = 1'b1;
        rsp_d       = cap_q >> (WIDTH_L - n_q);
      end
      ST_IDLECLK: begin
        if (cnt_q == n_q - ONE_L) begin
          state_d     = ST_READY;
          rsp_valid_d = 1'b1;
          rsp_d       = '0;
        end else begin
          cnt_d = cnt_q + ONE_L;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase

    // Pin values are decoded from the next state so tms/tdi leave a flop
    case (state_d)
      ST_INIT:  tms_d = (cnt_d != INIT_LAST);
      ST_PRE:   tms_d = (cnt_d == '0) || ((op_d == OP_IR) && (cnt_d == ONE_L));
      ST_SHIFT: begin
        tms_d = (cnt_d == n_d - ONE_L);
        tdi_d = sh_d[0];
      end
      ST_POST:  tms_d = 1'b1;
      default:  tms_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      op_q        <= OP_TLR;
      cnt_q       <= '0;
      n_q         <= ONE_L;
      sh_q        <= '0;
      cap_q       <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      tlr_rsp_q   <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      sh_q        <= sh_d;
      cap_q       <= cap_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
      tlr_rsp_q   <= tlr_rsp_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
    end
  end

  assign cmd_ready = (state_q == ST_READY);
  assign busy      = ~cmd_ready;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;

endmodule

`default_nettype wire
